// File: rtl/fadd_share_pkg.sv
// Shared types and defaults for the float-adder sharing controller.
package fadd_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int FP_W     = 32;
  localparam int GAP_DEF  = 4;
  localparam int WDOG_DEF = 64;

endpackage

// File: rtl/fadd_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt_oh,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     gnt_any
);
  localparam int IW = $clog2(N_REQ);

  int idx;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!gnt_any && req[idx]) begin
        gnt_any     = 1'b1;
        gnt_oh[idx] = 1'b1;
        gnt_idx     = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/fadd_share_ctrl.sv
// Shares one multi-cycle float adder among N_REQ requesters with round-robin grant and a re-arm gap.
// Optional done-pulse watchdog is built when FADD_SHARE_WDOG_EN is defined.
module fadd_share_ctrl
  import fadd_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = FP_W,
  parameter int GAP   = GAP_DEF,
  parameter int WDOG  = WDOG_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      a_in,
  input  logic [N_REQ*DW-1:0]      b_in,
  output logic [N_REQ-1:0]         gnt,
  output logic                     rsp_valid,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [DW-1:0]            rsp_data,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     add_str,
  output logic [DW-1:0]            add_a,
  output logic [DW-1:0]            add_b,
  input  logic                     add_done,
  input  logic [DW-1:0]            add_res,
  input  logic                     add_err
);
  localparam int IW    = $clog2(N_REQ);
  localparam int GAP_W = $clog2(GAP + 1);

  state_t           state, state_nxt;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    w_id;
  logic [IW-1:0]    arb_idx;
  logic [N_REQ-1:0] arb_oh;
  logic             arb_any;
  logic             wd_expire;
  logic [GAP_W-1:0] gap_cnt;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

`ifdef FADD_SHARE_WDOG_EN
  localparam int WD_W = $clog2(WDOG + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_expire = (state == WAIT) && (wd_cnt == WD_W'(WDOG - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)              wd_cnt <= '0;
    else if (state == START) wd_cnt <= '0;
    else if (state == WAIT)  wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_expire = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (arb_any) state_nxt = START;
      START: state_nxt = WAIT;
      WAIT:  if (add_done || wd_expire) state_nxt = fadd_share_pkg::GAP;
      fadd_share_pkg::GAP: if (gap_cnt == GAP_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured only on the grant edge and stay frozen until the next grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr       <= '0;
      w_id      <= '0;
      gap_cnt   <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      add_str   <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            add_a <= a_in[arb_idx*DW +: DW];
            add_b <= b_in[arb_idx*DW +: DW];
            w_id  <= arb_idx;
            gnt   <= arb_oh;
            ptr   <= (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
          end
        end
        START: add_str <= 1'b1;
        WAIT: begin
          if (add_done) begin
            rsp_valid <= 1'b1;
            rsp_data  <= add_res;
            rsp_err   <= add_err;
            rsp_id    <= w_id;
            add_str   <= 1'b0;
            gap_cnt   <= GAP_W'(GAP);
          end else if (wd_expire) begin
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= 1'b1;
            rsp_id    <= w_id;
            add_str   <= 1'b0;
            gap_cnt   <= GAP_W'(GAP);
          end
        end
        fadd_share_pkg::GAP: gap_cnt <= gap_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fadd_share_ctrl.sv
// Directed bench for fadd_share_ctrl with a fixed-latency behavioural adder.
module tb_fadd_share_ctrl;
  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int GAPC = 4;
  localparam int WDOG = 64;
  localparam int LAT  = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N*DW-1:0] a_in, b_in;
  logic [N-1:0]  gnt;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          busy;
  logic          add_str;
  logic [DW-1:0] add_a, add_b;
  logic          add_done;
  logic [DW-1:0] add_res;
  logic          add_err;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  mdl_cnt = 0;
  bit  mdl_fired = 1'b0;
  bit  mdl_on    = 1'b1;
  bit  mdl_err   = 1'b0;
  bit  inj_done  = 1'b0;

  fadd_share_ctrl #(.N_REQ(N), .DW(DW), .GAP(GAPC), .WDOG(WDOG)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .add_str(add_str), .add_a(add_a),
    .add_b(add_b), .add_done(add_done), .add_res(add_res), .add_err(add_err)
  );

  always #5 clk = ~clk;

  // Known float sums; anything else returns a ^ b so tagging is still checkable.
  function automatic logic [31:0] fadd_lut(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] key;
    key = {a, b};
    case (key)
      64'h3F800000_40000000: return 32'h40400000;
      64'h3FC00000_BF000000: return 32'h3F800000;
      default:               return a ^ b;
    endcase
  endfunction

  // Adder model: done pulses LAT cycles after the start level rises.
  always @(negedge clk) begin
    add_done = 1'b0;
    add_err  = 1'b0;
    if (inj_done) begin
      add_done = 1'b1;
      add_res  = 32'hDEADBEEF;
      inj_done = 1'b0;
    end else if (add_str) begin
      if (!mdl_fired) begin
        mdl_cnt++;
        if (mdl_on && mdl_cnt == LAT) begin
          add_done  = 1'b1;
          add_res   = fadd_lut(add_a, add_b);
          add_err   = mdl_err;
          mdl_fired = 1'b1;
        end
      end
    end else begin
      mdl_cnt   = 0;
      mdl_fired = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int cyc, output bit seen);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      tick(); cyc++;
      if (gnt != '0) seen = 1'b1;
    end
  endtask

  task automatic wait_rsp(output int cyc, output bit seen);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      tick(); cyc++;
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 200) begin
      tick(); c++;
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_timeout: busy=%b want 0", busy);
    end
  endtask

  task automatic set_lane(input int k, input logic [31:0] a, input logic [31:0] b);
    a_in[k*DW +: DW] = a;
    b_in[k*DW +: DW] = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; a_in = '0; b_in = '0;
    tick(); tick();
    n_tests++;
    if ({gnt, rsp_valid, rsp_err, busy, add_str} !== '0) begin
      n_fail++; $display("FAIL reset_ctrl: gnt=%b rv=%b err=%b busy=%b str=%b want 0", gnt, rsp_valid, rsp_err, busy, add_str);
    end
    n_tests++;
    if ({add_a, add_b, rsp_data, rsp_id} !== '0) begin
      n_fail++; $display("FAIL reset_data: a=%h b=%h d=%h id=%0d want 0", add_a, add_b, rsp_data, rsp_id);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int cyc; bit seen;
    set_lane(2, 32'h3F800000, 32'h40000000);
    req = 4'b0100;
    wait_gnt(cyc, seen);
    n_tests++;
    if (!seen || gnt !== 4'b0100 || cyc != 1) begin
      n_fail++; $display("FAIL single_gnt: gnt=%b cyc=%0d want 0100 cyc=1", gnt, cyc);
    end
    req = '0;
    tick();
    n_tests++;
    if (gnt !== 4'b0000 || add_str !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_start: gnt=%b str=%b busy=%b want 0000 1 1", gnt, add_str, busy);
    end
    n_tests++;
    if (add_a !== 32'h3F800000 || add_b !== 32'h40000000) begin
      n_fail++; $display("FAIL single_ops: a=%h b=%h want 3f800000 40000000", add_a, add_b);
    end
    wait_rsp(cyc, seen);
    n_tests++;
    if (!seen || cyc != LAT) begin
      n_fail++; $display("FAIL single_latency: seen=%b cyc=%0d want %0d", seen, cyc, LAT);
    end
    n_tests++;
    if (rsp_id !== 2'd2 || rsp_data !== 32'h40400000 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp: id=%0d d=%h err=%b want 2 40400000 0", rsp_id, rsp_data, rsp_err);
    end
    tick();
    n_tests++;
    if (rsp_valid !== 1'b0 || add_str !== 1'b0) begin
      n_fail++; $display("FAIL single_pulse: rv=%b str=%b want 0 0", rsp_valid, add_str);
    end
    wait_idle();
  endtask

  task automatic test_contention();
    int cyc; bit seen; bit gap_ok; int lane;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int k = 0; k < N; k++) set_lane(k, 32'hA0000000 | k, 32'h00000F00 << k);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      lane = i % N;
      gap_ok = 1'b1; cyc = 0; seen = 1'b0;
      while (!seen && cyc < 200) begin
        tick(); cyc++;
        if (gnt != '0) seen = 1'b1;
        else if (add_str !== 1'b0) gap_ok = 1'b0;
      end
      n_tests++;
      if (!seen || gnt !== (4'b0001 << lane)) begin
        n_fail++; $display("FAIL cont_order%0d: gnt=%b want lane %0d", i, gnt, lane);
      end
      if (i > 0) begin
        n_tests++;
        if (cyc < GAPC + 1 || !gap_ok) begin
          n_fail++; $display("FAIL cont_gap%0d: spacing=%0d str_low=%b want >=%0d 1", i, cyc, gap_ok, GAPC + 1);
        end
      end
      wait_rsp(cyc, seen);
      n_tests++;
      if (!seen || rsp_id !== lane[1:0] ||
          rsp_data !== ((32'hA0000000 | lane) ^ (32'h00000F00 << lane))) begin
        n_fail++; $display("FAIL cont_rsp%0d: id=%0d d=%h want %0d %h", i, rsp_id, rsp_data, lane,
                           (32'hA0000000 | lane) ^ (32'h00000F00 << lane));
      end
    end
    req = '0;
    wait_idle();
  endtask

  task automatic test_operand_hold();
    int cyc; bit seen;
    set_lane(0, 32'h3FC00000, 32'hBF000000);
    req = 4'b0001;
    wait_gnt(cyc, seen);
    n_tests++;
    if (!seen || gnt !== 4'b0001) begin
      n_fail++; $display("FAIL hold_gnt: gnt=%b want 0001", gnt);
    end
    req = '0;
    tick(); tick();
    set_lane(0, 32'h12345678, 32'h0BADF00D);
    tick();
    n_tests++;
    if (add_a !== 32'h3FC00000 || add_b !== 32'hBF000000) begin
      n_fail++; $display("FAIL hold_ops: a=%h b=%h want 3fc00000 bf000000", add_a, add_b);
    end
    wait_rsp(cyc, seen);
    n_tests++;
    if (!seen || rsp_data !== 32'h3F800000 || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL hold_rsp: d=%h id=%0d want 3f800000 0", rsp_data, rsp_id);
    end
    wait_idle();
  endtask

  task automatic test_error();
    int cyc; bit seen;
    set_lane(1, 32'h3F800000, 32'h40000000);
    set_lane(3, 32'h3F800000, 32'h40000000);
    mdl_err = 1'b1;
    req = 4'b0010;
    wait_gnt(cyc, seen);
    req = '0;
    wait_rsp(cyc, seen);
    n_tests++;
    if (!seen || rsp_err !== 1'b1 || rsp_id !== 2'd1) begin
      n_fail++; $display("FAIL err_flag: err=%b id=%0d want 1 1", rsp_err, rsp_id);
    end
    mdl_err = 1'b0;
    wait_idle();
    req = 4'b1000;
    wait_gnt(cyc, seen);
    n_tests++;
    if (!seen || gnt !== 4'b1000) begin
      n_fail++; $display("FAIL err_next_gnt: gnt=%b want 1000", gnt);
    end
    req = '0;
    wait_rsp(cyc, seen);
    n_tests++;
    if (!seen || rsp_err !== 1'b0 || rsp_data !== 32'h40400000 || rsp_id !== 2'd3) begin
      n_fail++; $display("FAIL err_next_rsp: err=%b d=%h id=%0d want 0 40400000 3", rsp_err, rsp_data, rsp_id);
    end
    wait_idle();
  endtask

  task automatic test_stray_and_drop();
    int cyc; bit seen; bit quiet;
    inj_done = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++; $display("FAIL stray_idle: rv/busy rose=%b want 0", !quiet);
    end
    // ptr is 0 after lane 3; lane 2 grant leaves ptr at 3
    set_lane(2, 32'h3F800000, 32'h40000000);
    req = 4'b0100;
    wait_gnt(cyc, seen);
    req = '0;
    wait_rsp(cyc, seen);
    tick();
    req = 4'b1010;
    tick(); tick();
    req = 4'b0010;
    wait_gnt(cyc, seen);
    n_tests++;
    if (!seen || gnt !== 4'b0010) begin
      n_fail++; $display("FAIL drop_forgotten: gnt=%b want 0010", gnt);
    end
    n_tests++;
    if (cyc != 2) begin
      n_fail++; $display("FAIL gap_queue: wait=%0d want 2", cyc);
    end
    req = '0;
    wait_rsp(cyc, seen);
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int cyc; bit seen; bit quiet;
    set_lane(2, 32'h3F800000, 32'h40000000);
    set_lane(3, 32'h3F800000, 32'h40000000);
    req = 4'b0100;
    wait_gnt(cyc, seen);
    req = '0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    n_tests++;
    if (add_str !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || gnt !== '0) begin
      n_fail++; $display("FAIL rstmid_ctrl: str=%b busy=%b rv=%b gnt=%b want 0", add_str, busy, rsp_valid, gnt);
    end
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rsp_valid !== 1'b0) quiet = 1'b0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++; $display("FAIL rstmid_norsp: rv rose=%b want 0", !quiet);
    end
    req = 4'b1100;
    wait_gnt(cyc, seen);
    n_tests++;
    if (!seen || gnt !== 4'b0100) begin
      n_fail++; $display("FAIL rstmid_ptr: gnt=%b want 0100", gnt);
    end
    req = '0;
    wait_rsp(cyc, seen);
    wait_idle();
  endtask

`ifdef FADD_SHARE_WDOG_EN
  task automatic test_wdog();
    int cyc; bit seen; bit quiet;
    mdl_on = 1'b0;
    set_lane(0, 32'h3F800000, 32'h40000000);
    req = 4'b0001;
    wait_gnt(cyc, seen);
    req = '0;
    wait_rsp(cyc, seen);
    n_tests++;
    if (!seen || cyc != WDOG + 1) begin
      n_fail++; $display("FAIL wdog_time: seen=%b cyc=%0d want %0d", seen, cyc, WDOG + 1);
    end
    n_tests++;
    if (rsp_err !== 1'b1 || rsp_data !== 32'h0 || rsp_id !== 2'd0) begin
      n_fail++; $display("FAIL wdog_rsp: err=%b d=%h id=%0d want 1 0 0", rsp_err, rsp_data, rsp_id);
    end
    tick();
    inj_done = 1'b1;
    quiet = (add_str === 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp_valid !== 1'b0) quiet = 1'b0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++; $display("FAIL wdog_late_done: str/rv misbehaved=%b want 0", !quiet);
    end
    mdl_on = 1'b1;
    wait_idle();
  endtask
`endif

  initial begin
    add_done = 1'b0; add_res = '0; add_err = 1'b0;
    rst_n = 1'b0; req = '0; a_in = '0; b_in = '0;
    test_reset();
    test_single();
    test_contention();
    test_operand_hold();
    test_error();
    test_stray_and_drop();
    test_reset_mid();
`ifdef FADD_SHARE_WDOG_EN
    test_wdog();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
